// File: rtl/rv_plic_core_pkg.sv
// Shared types and helpers for the PLIC gateway/arbitration core.
package rv_plic_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } gw_state_e;

    // Higher priority wins; equal priority goes to the lower ID.
    function automatic logic prio_beats(input int unsigned cand_prio,
                                        input int unsigned cand_id,
                                        input int unsigned best_prio,
                                        input int unsigned best_id);
        return (cand_prio > best_prio) ||
               ((cand_prio == best_prio) && (cand_id < best_id));
    endfunction

endpackage

// File: rtl/rv_plic_core_gateway.sv
// Single-source interrupt gateway: IDLE/PEND/SERV FSM with a saturating
// edge-event counter and a sticky overflow flag.
module rv_plic_core_gateway
    import rv_plic_core_pkg::*;
#(
    parameter int unsigned EDGE_CNTW = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    input  logic ovf_clr_i,
    output logic ip_o,
    output logic ovf_o
);

    gw_state_e              state_q, state_d;
    logic [EDGE_CNTW-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   src_q;
    logic                   ip_q;
    logic                   rise;
    logic                   take;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        rise    = src_i & ~src_q;
        take    = 1'b0;
        case (state_q)
            IDLE: if (le_i ? (cnt_q != '0) : src_i) begin
                state_d = PEND;
                take    = le_i;
            end
            PEND: if (claim_i) state_d = SERV;
            SERV: if (complete_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A simultaneous edge and dequeue cancel out; overflow only on a net increment.
        if (!le_i) begin
            cnt_d = '0;
        end else if (rise && !take) begin
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + EDGE_CNTW'(1);
        end else if (take && !rise) begin
            cnt_d = cnt_q - EDGE_CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            src_q   <= 1'b0;
            ip_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            src_q   <= src_i;
            ip_q    <= (state_d == PEND);
        end
    end

    assign ip_o  = ip_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/rv_plic_core.sv
// PLIC core: per-source gateways plus per-target max-priority arbitration.
// Source ID k (1..N_SOURCE) lives at bit k-1 of every per-source vector.
module rv_plic_core
    import rv_plic_core_pkg::*;
#(
    parameter int unsigned N_SOURCE  = 32,
    parameter int unsigned N_TARGET  = 2,
    parameter int unsigned MAX_PRIO  = 7,
    parameter int unsigned EDGE_CNTW = 2,
    parameter int unsigned SRCW      = $clog2(N_SOURCE + 1),
    parameter int unsigned PRIOW     = $clog2(MAX_PRIO + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SOURCE-1:0]        intr_src_i,
    input  logic [N_SOURCE-1:0]        le_i,
    input  logic [N_SOURCE*PRIOW-1:0]  prio_i,
    input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
    input  logic [N_TARGET*PRIOW-1:0]  threshold_i,
    input  logic [N_TARGET-1:0]        claim_i,
    input  logic [N_TARGET-1:0]        complete_i,
    input  logic [N_TARGET*SRCW-1:0]   complete_id_i,
    input  logic [N_SOURCE-1:0]        ovf_clr_i,
    output logic [N_SOURCE-1:0]        ip_o,
    output logic [N_SOURCE-1:0]        ovf_o,
    output logic [N_TARGET-1:0]        irq_o,
    output logic [N_TARGET*SRCW-1:0]   irq_id_o
);

    logic [N_SOURCE-1:0] claim;
    logic [N_SOURCE-1:0] complete;

    // Out-of-range or zero IDs never match any source, so they drop out here.
    always_comb begin
        claim    = '0;
        complete = '0;
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            for (int unsigned s = 0; s < N_SOURCE; s++) begin
                if (claim_i[t] && (irq_id_o[t*SRCW +: SRCW] == SRCW'(s + 1)))
                    claim[s] = 1'b1;
                if (complete_i[t] && (complete_id_i[t*SRCW +: SRCW] == SRCW'(s + 1)))
                    complete[s] = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < N_SOURCE; s++) begin : g_gw
        rv_plic_core_gateway #(
            .EDGE_CNTW (EDGE_CNTW)
        ) u_gw (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (intr_src_i[s]),
            .le_i       (le_i[s]),
            .claim_i    (claim[s]),
            .complete_i (complete[s]),
            .ovf_clr_i  (ovf_clr_i[s]),
            .ip_o       (ip_o[s]),
            .ovf_o      (ovf_o[s])
        );
    end

    for (genvar t = 0; t < N_TARGET; t++) begin : g_tgt
        logic [PRIOW-1:0] best_prio;
        logic [SRCW-1:0]  best_id;
        logic             irq_q;
        logic [SRCW-1:0]  irq_id_q;

        always_comb begin
            best_prio = '0;
            best_id   = '0;
            for (int unsigned s = 0; s < N_SOURCE; s++) begin
                if (ip_o[s] && ie_i[t*N_SOURCE + s] &&
                    (prio_i[s*PRIOW +: PRIOW] != '0) &&
                    prio_beats(32'(prio_i[s*PRIOW +: PRIOW]), s + 1,
                               32'(best_prio), 32'(best_id))) begin
                    best_prio = prio_i[s*PRIOW +: PRIOW];
                    best_id   = SRCW'(s + 1);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                irq_q    <= 1'b0;
                irq_id_q <= '0;
            end else begin
                irq_q    <= (best_prio > threshold_i[t*PRIOW +: PRIOW]);
                irq_id_q <= best_id;
            end
        end

        assign irq_o[t]                  = irq_q;
        assign irq_id_o[t*SRCW +: SRCW]  = irq_id_q;
    end

endmodule

// File: tb/tb_rv_plic_core.sv
// Self-checking bench for rv_plic_core: directed vectors, corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_rv_plic_core;

    localparam int N     = 32;
    localparam int T     = 2;
    localparam int CW    = 2;
    localparam int SRCW  = 6;
    localparam int PRIOW = 3;
    localparam int CMAX  = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      src = '0;
    logic [N-1:0]      le = '0;
    logic [N*PRIOW-1:0] prio = '0;
    logic [T*N-1:0]    ie = '0;
    logic [T*PRIOW-1:0] thr = '0;
    logic [T-1:0]      claim = '0;
    logic [T-1:0]      comp = '0;
    logic [T*SRCW-1:0] cid = '0;
    logic [N-1:0]      ovf_clr = '0;
    logic [N-1:0]      ip_o, ovf_o;
    logic [T-1:0]      irq_o;
    logic [T*SRCW-1:0] irq_id_o;

    rv_plic_core #(
        .N_SOURCE  (N),
        .N_TARGET  (T),
        .MAX_PRIO  (7),
        .EDGE_CNTW (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .intr_src_i    (src),
        .le_i          (le),
        .prio_i        (prio),
        .ie_i          (ie),
        .threshold_i   (thr),
        .claim_i       (claim),
        .complete_i    (comp),
        .complete_id_i (cid),
        .ovf_clr_i     (ovf_clr),
        .ip_o          (ip_o),
        .ovf_o         (ovf_o),
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Behavioural model, indexed by source ID 1..N.
    bit m_pend[1:N];
    bit m_serv[1:N];
    int m_backlog[1:N];
    bit m_ovf[1:N];
    bit m_prev[1:N];
    bit m_irq[T];
    int m_id[T];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pr(input int id);
        return int'(prio[(id-1)*PRIOW +: PRIOW]);
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= N; i++) begin
            m_pend[i] = 0; m_serv[i] = 0; m_backlog[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
        end
        for (int t = 0; t < T; t++) begin
            m_irq[t] = 0; m_id[t] = 0;
        end
    endtask

    task automatic model_clock();
        bit nirq[T];
        int nid[T];
        for (int t = 0; t < T; t++) begin
            int best = 0;
            int who = 0;
            for (int i = 1; i <= N; i++)
                if (m_pend[i] && ie[t*N + i - 1] && pr(i) > best) begin
                    best = pr(i);
                    who = i;
                end
            nirq[t] = best > int'(thr[t*PRIOW +: PRIOW]);
            nid[t] = who;
        end
        for (int i = 1; i <= N; i++) begin
            bit claimed = 0;
            bit done = 0;
            bit idle = !m_pend[i] && !m_serv[i];
            bit rise = src[i-1] && !m_prev[i];
            bit start;
            for (int t = 0; t < T; t++) begin
                if (claim[t] && m_id[t] == i) claimed = 1;
                if (comp[t] && int'(cid[t*SRCW +: SRCW]) == i) done = 1;
            end
            start = idle && (le[i-1] ? (m_backlog[i] > 0) : src[i-1]);
            if (m_ovf[i] && ovf_clr[i-1]) m_ovf[i] = 0;
            if (start) m_pend[i] = 1;
            else if (m_pend[i] && claimed) begin m_pend[i] = 0; m_serv[i] = 1; end
            else if (m_serv[i] && done) m_serv[i] = 0;
            if (!le[i-1]) m_backlog[i] = 0;
            else begin
                int net = (rise ? 1 : 0) - ((start && le[i-1]) ? 1 : 0);
                if (net > 0) begin
                    if (m_backlog[i] == CMAX) m_ovf[i] = 1;
                    else m_backlog[i]++;
                end else if (net < 0) m_backlog[i]--;
            end
            m_prev[i] = src[i-1];
        end
        for (int t = 0; t < T; t++) begin
            m_irq[t] = nirq[t];
            m_id[t] = nid[t];
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eip, eovf;
        logic [T-1:0] eirq;
        logic [T*SRCW-1:0] eid;
        for (int i = 1; i <= N; i++) begin
            eip[i-1] = m_pend[i];
            eovf[i-1] = m_ovf[i];
        end
        for (int t = 0; t < T; t++) begin
            eirq[t] = m_irq[t];
            eid[t*SRCW +: SRCW] = SRCW'(m_id[t]);
        end
        chk("model_ip", ip_o, eip);
        chk("model_ovf", ovf_o, eovf);
        chk("model_irq", irq_o, eirq);
        chk("model_irq_id", irq_id_o, eid);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        src = '0; le = '0; prio = '0; ie = '0; thr = '0;
        claim = '0; comp = '0; cid = '0; ovf_clr = '0;
        model_reset();
        @(posedge clk_i);
        #1;
        check_all();
        rst_ni = 1'b1;
    endtask

    task automatic set_prio(input int id, input int p);
        prio[(id-1)*PRIOW +: PRIOW] = PRIOW'(p);
    endtask

    // Wait (bounded) for target t to present id, then claim it for one cycle.
    task automatic serve(input int t, input int id);
        int n = 0;
        while (m_id[t] != id && n < 20) begin
            step();
            n++;
        end
        chk("serve_id_visible", irq_id_o[t*SRCW +: SRCW], SRCW'(id));
        claim[t] = 1'b1;
        step();
        claim[t] = 1'b0;
    endtask

    task automatic pulse(input int id);
        src[id-1] = 1'b1;
        step();
        src[id-1] = 1'b0;
        step();
    endtask

    task automatic complete_id(input int t, input int id);
        comp[t] = 1'b1;
        cid[t*SRCW +: SRCW] = SRCW'(id);
        step();
        comp[t] = 1'b0;
        cid[t*SRCW +: SRCW] = '0;
    endtask

    typedef struct {
        logic [N-1:0]    src;
        logic [T-1:0]    claim;
        logic [T-1:0]    comp;
        logic [SRCW-1:0] cid0;
        logic [N-1:0]    exp_ip;
        logic [T-1:0]    exp_irq;
        logic [SRCW-1:0] exp_id0;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{src: 32'h4, claim: 2'b00, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h4, exp_irq: 2'b00, exp_id0: 6'd0};
        tbl[1] = '{src: 32'h4, claim: 2'b00, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h4, exp_irq: 2'b01, exp_id0: 6'd3};
        tbl[2] = '{src: 32'h4, claim: 2'b01, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h0, exp_irq: 2'b01, exp_id0: 6'd3};
        tbl[3] = '{src: 32'h4, claim: 2'b00, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h0, exp_irq: 2'b00, exp_id0: 6'd0};
        tbl[4] = '{src: 32'h4, claim: 2'b00, comp: 2'b01, cid0: 6'd3, exp_ip: 32'h0, exp_irq: 2'b00, exp_id0: 6'd0};
        tbl[5] = '{src: 32'h4, claim: 2'b00, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h4, exp_irq: 2'b00, exp_id0: 6'd0};
        tbl[6] = '{src: 32'h4, claim: 2'b00, comp: 2'b00, cid0: 6'd0, exp_ip: 32'h4, exp_irq: 2'b01, exp_id0: 6'd3};

        // Reset state
        #3;
        chk("reset_ip", ip_o, '0);
        chk("reset_irq", irq_o, '0);
        chk("reset_irq_id", irq_id_o, '0);
        do_reset();

        // Level source: latency, claim, complete with source still high
        set_prio(3, 2);
        ie[2] = 1'b1;
        thr[0 +: PRIOW] = 3'd1;
        for (int k = 0; k < 7; k++) begin
            src = tbl[k].src;
            claim = tbl[k].claim;
            comp = tbl[k].comp;
            cid[0 +: SRCW] = tbl[k].cid0;
            step();
            chk($sformatf("vec%0d_ip", k), ip_o, tbl[k].exp_ip);
            chk($sformatf("vec%0d_irq", k), irq_o, tbl[k].exp_irq);
            chk($sformatf("vec%0d_id0", k), irq_id_o[0 +: SRCW], tbl[k].exp_id0);
        end
        claim = '0; comp = '0; cid = '0;

        // Priority and tie-break, threshold gating
        do_reset();
        set_prio(2, 4); set_prio(5, 4); set_prio(7, 6);
        ie[1] = 1'b1; ie[4] = 1'b1; ie[6] = 1'b1;
        thr[0 +: PRIOW] = 3'd1;
        src[1] = 1'b1; src[4] = 1'b1; src[6] = 1'b1;
        step(); step();
        chk("prio_max_id", irq_id_o[0 +: SRCW], 6'd7);
        set_prio(7, 4);
        step();
        chk("prio_tie_id", irq_id_o[0 +: SRCW], 6'd2);
        thr[0 +: PRIOW] = 3'd4;
        step();
        chk("thr_irq_low", irq_o[0], 1'b0);
        chk("thr_id_kept", irq_id_o[0 +: SRCW], 6'd2);

        // Edge counting, saturation, overflow and drain
        do_reset();
        le[0] = 1'b1;
        set_prio(1, 1);
        ie[0] = 1'b1;
        pulse(1);
        serve(0, 1);
        for (int k = 0; k < 5; k++) pulse(1);
        chk("edge_ovf_set", ovf_o[0], 1'b1);
        chk("edge_in_serv", ip_o[0], 1'b0);
        for (int r = 0; r < 3; r++) begin
            complete_id(0, 1);
            step();
            chk($sformatf("edge_repend%0d", r), ip_o[0], 1'b1);
            serve(0, 1);
        end
        complete_id(0, 1);
        for (int k = 0; k < 4; k++) step();
        chk("edge_drained", ip_o[0], 1'b0);
        ovf_clr[0] = 1'b1;
        step();
        ovf_clr[0] = 1'b0;
        chk("ovf_cleared", ovf_o[0], 1'b0);

        // Multi-target simultaneous claim, complete from one target
        do_reset();
        set_prio(4, 3);
        ie[3] = 1'b1; ie[N + 3] = 1'b1;
        src[3] = 1'b1;
        step(); step();
        chk("mt_id0", irq_id_o[0 +: SRCW], 6'd4);
        chk("mt_id1", irq_id_o[SRCW +: SRCW], 6'd4);
        claim = 2'b11;
        step();
        claim = '0;
        src[3] = 1'b0;
        chk("mt_claimed", ip_o[3], 1'b0);
        complete_id(1, 4);
        src[3] = 1'b1;
        step();
        chk("mt_back_idle", ip_o[3], 1'b1);

        // Illegal complete / claim
        do_reset();
        set_prio(6, 2);
        ie[5] = 1'b1;
        src[5] = 1'b1;
        step(); step();
        complete_id(0, 0);
        complete_id(0, 33);
        complete_id(1, 6);
        chk("illegal_cmp", ip_o[5], 1'b1);
        claim[1] = 1'b1;
        step();
        claim[1] = 1'b0;
        chk("claim_id0", ip_o[5], 1'b1);

        // Reset mid-service; edge source held high across release
        do_reset();
        le[0] = 1'b1;
        set_prio(1, 2); set_prio(3, 1);
        ie[0] = 1'b1; ie[2] = 1'b1;
        pulse(1);
        serve(0, 1);
        pulse(1); pulse(1);
        src[2] = 1'b1;
        src[0] = 1'b1;
        step(); step();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_ip", ip_o, '0);
        chk("rst_ovf", ovf_o, '0);
        chk("rst_irq", irq_o, '0);
        chk("rst_irq_id", irq_id_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(); step();
        chk("rst_edge_pend", ip_o[0], 1'b1);
        src = '0;

        // Randomized traffic against the model
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            le = $urandom;
            prio = {$urandom, $urandom, $urandom};
            ie = {$urandom, $urandom};
            thr = 6'($urandom);
            for (int c = 0; c < 100; c++) begin
                src = $urandom & $urandom;
                if ($urandom_range(0, 15) == 0) le[$urandom_range(0, N-1)] ^= 1'b1;
                claim = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
                ovf_clr = $urandom & $urandom & $urandom;
                for (int t = 0; t < T; t++) begin
                    int pick = $urandom_range(0, 35);
                    for (int tries = 0; tries < 8 && $urandom_range(0, 3) != 0; tries++) begin
                        int cand = $urandom_range(1, N);
                        if (m_serv[cand]) begin
                            pick = cand;
                            break;
                        end
                    end
                    comp[t] = 1'($urandom_range(0, 1));
                    cid[t*SRCW +: SRCW] = SRCW'(pick);
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
